// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin memory arbiter and its picker.
// The bus widths match the existing mem interface address and data buses.
package mem_rr_arbiter_pkg;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int WIDTH_W     = 4;
  localparam int ARB_REQ_NUM = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Wraps at n rather than at a power of two, so non-power-of-two requester counts rotate correctly.
  function automatic int ptr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/mem_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request at or after ptr, wrapping.
// Kept generic so other arbiters can reuse it.
module rr_picker
  import mem_rr_arbiter_pkg::*;
#(
  parameter int REQ_NUM = ARB_REQ_NUM,
  parameter int ID_W    = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    grant
);

  logic [ID_W-1:0]    cand_idx [REQ_NUM];
  logic [REQ_NUM-1:0] cand_req;

  // Slot gi is the requester gi positions after ptr in rotation order.
  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_cand
      assign cand_idx[gi] = ID_W'((int'(ptr) + gi) % REQ_NUM);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        valid = 1'b1;
        grant = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one mem word-access port among REQ_NUM requesters.
// Exactly one downstream transaction is in flight; a dead cycle follows each completion.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int REQ_NUM = ARB_REQ_NUM,
  parameter int ID_W    = $clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req_ce_i,
  input  logic [REQ_NUM-1:0] req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i  [0:REQ_NUM-1],
  input  logic [WIDTH_W-1:0] req_width_i [0:REQ_NUM-1],
  input  logic [DATA_W-1:0]  req_data_i  [0:REQ_NUM-1],
  output logic [DATA_W-1:0]  req_data_o  [0:REQ_NUM-1],
  output logic [REQ_NUM-1:0] req_ready_o,
  output logic               mem_ce_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [WIDTH_W-1:0] mem_width_o,
  output logic [DATA_W-1:0]  mem_data_o,
  input  logic [DATA_W-1:0]  mem_data_i,
  input  logic               mem_ready_i,
  output logic               busy_o,
  output logic [ID_W-1:0]    grant_id_o
);

  arb_state_t state_reg, state_next;

  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    grant_reg;
  logic               mem_ce_reg;
  logic               mem_we_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [WIDTH_W-1:0] mem_width_reg;
  logic [DATA_W-1:0]  mem_data_reg;
  logic [REQ_NUM-1:0] req_ready_reg;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic               issue_en;
  logic               done_en;

  rr_picker #(
    .REQ_NUM(REQ_NUM),
    .ID_W   (ID_W)
  ) u_picker (
    .req  (req_ce_i),
    .ptr  (ptr_reg),
    .valid(pick_valid),
    .grant(pick_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue_en   = 1'b0;
    done_en    = 1'b0;
    unique case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) begin
          issue_en   = 1'b1;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_ready_i) begin
          done_en    = 1'b1;
          state_next = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  // Request fields are captured once at grant, so requesters may change them during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      grant_reg     <= '0;
      mem_ce_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_width_reg <= '0;
      mem_data_reg  <= '0;
      req_ready_reg <= '0;
    end else begin
      req_ready_reg <= '0;
      if (issue_en) begin
        grant_reg     <= pick_id;
        mem_ce_reg    <= 1'b1;
        mem_we_reg    <= req_we_i[pick_id];
        mem_addr_reg  <= req_addr_i[pick_id];
        mem_width_reg <= req_width_i[pick_id];
        mem_data_reg  <= req_data_i[pick_id];
      end
      if (done_en) begin
        mem_ce_reg               <= 1'b0;
        req_ready_reg[grant_reg] <= 1'b1;
        ptr_reg                  <= ID_W'(ptr_wrap_inc(int'(grant_reg), REQ_NUM));
      end
    end
  end

  // Each requester's read data holds until its own next completion; writes return zero.
  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rdata
      logic [DATA_W-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (done_en && (grant_reg == ID_W'(gi))) begin
          data_reg <= mem_we_reg ? '0 : mem_data_i;
        end
      end
      assign req_data_o[gi] = data_reg;
    end
  endgenerate

  assign req_ready_o = req_ready_reg;
  assign mem_ce_o    = mem_ce_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_width_o = mem_width_reg;
  assign mem_data_o  = mem_data_reg;
  assign busy_o      = (state_reg != ARB_IDLE);
  assign grant_id_o  = grant_reg;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomized scoreboard bench for mem_rr_arbiter: a transaction-level model predicts grants
// and completions into queues; a monitor pops and compares whenever the DUT presents them.
module tb_mem_rr_arbiter;
  import mem_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_ce;
  logic [N-1:0]  req_we;
  logic [31:0]   req_addr  [0:N-1];
  logic [3:0]    req_width [0:N-1];
  logic [31:0]   req_wdata [0:N-1];
  logic [31:0]   req_rdata [0:N-1];
  logic [N-1:0]  req_ready;
  logic          mem_ce;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_width;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          busy;
  logic [IW-1:0] grant_id;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.REQ_NUM(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_ce_i   (req_ce),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_width_i(req_width),
    .req_data_i (req_wdata),
    .req_data_o (req_rdata),
    .req_ready_o(req_ready),
    .mem_ce_o   (mem_ce),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_width_o(mem_width),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .mem_ready_i(mem_ready),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t req_q[$];
  txn_t cpl_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: 0 = waiting for requests, 1 = access outstanding, 2 = dead cycle.
  int          m_state = 0;
  int          m_ptr   = 0;
  int          m_gid   = 0;
  int          lat     = 0;
  txn_t        cur;
  bit          active  [N];
  bit          granted [N];
  bit          done    [N];
  logic [31:0] exp_rdata [N];
  int          p_new, p_drop, p_stray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One model step: choose inputs for the coming edge, then apply the arbitration rules to them.
  task automatic drive_step(input bit do_rst, input bit force_ready);
    int   w;
    bit   rdy;
    txn_t t;
    rst = do_rst;
    for (int i = 0; i < N; i++) begin
      if (do_rst || done[i]) begin
        active[i]  = 1'b0;
        granted[i] = 1'b0;
        done[i]    = 1'b0;
        req_ce[i]  = 1'b0;
      end else if (!active[i]) begin
        if ($urandom_range(99) < p_new) begin
          active[i]    = 1'b1;
          req_ce[i]    = 1'b1;
          req_we[i]    = 1'($urandom_range(1));
          req_addr[i]  = $urandom & 32'hFFFF_FFFC;
          req_width[i] = 4'($urandom);
          req_wdata[i] = $urandom;
        end
      end else if (granted[i] && ($urandom_range(99) < p_drop)) begin
        req_ce[i]    = 1'b0;
        req_we[i]    = ~req_we[i];
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
      end
    end

    mem_rdata = $urandom;
    if (do_rst) rdy = 1'b0;
    else if (force_ready) rdy = 1'b1;
    else if (m_state == 1) begin
      if (lat == 0) rdy = 1'b1;
      else begin
        lat--;
        rdy = 1'b0;
      end
    end else rdy = ($urandom_range(99) < p_stray);
    mem_ready = rdy;

    if (do_rst) begin
      m_state = 0;
      m_ptr   = 0;
      m_gid   = 0;
      for (int i = 0; i < N; i++) exp_rdata[i] = 32'h0;
    end else begin
      case (m_state)
        0: begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req_ce[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          if (w >= 0) begin
            t.id    = w;
            t.we    = req_we[w];
            t.addr  = req_addr[w];
            t.width = req_width[w];
            t.data  = req_wdata[w];
            t.cyc   = cyc + 1;
            req_q.push_back(t);
            cur        = t;
            m_gid      = w;
            granted[w] = 1'b1;
            lat        = $urandom_range(4);
            m_state    = 1;
          end
        end
        1: begin
          if (rdy) begin
            t      = cur;
            t.data = cur.we ? 32'h0 : mem_rdata;
            t.cyc  = cyc + 1;
            cpl_q.push_back(t);
            exp_rdata[m_gid] = t.data;
            done[m_gid]      = 1'b1;
            m_ptr            = (m_gid + 1) % N;
            m_state          = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues downstream or pulses a ready.
  txn_t live;
  txn_t got;
  bit   prev_ce = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      check("rst_ctrl", 32'({mem_ce, mem_we, busy, req_ready, grant_id, mem_width}), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      for (int i = 0; i < N; i++) check("rst_rdata", req_rdata[i], 32'h0);
      prev_ce = 1'b0;
    end else begin
      if (req_q.size() > 0 && req_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: got no mem_ce_o required issue for req%0d by cycle %0d",
                 req_q[0].id, req_q[0].cyc);
        req_q.delete(0);
      end
      if (cpl_q.size() > 0 && cpl_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: got no req_ready_o required ready for req%0d by cycle %0d",
                 cpl_q[0].id, cpl_q[0].cyc);
        cpl_q.delete(0);
      end

      if (mem_ce && !prev_ce) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue_unexpected: got mem_ce_o=1 id=%0d required no issue (cycle %0d)",
                   grant_id, cyc);
        end else begin
          live = req_q.pop_front();
          check("issue_cycle", 32'(cyc), 32'(live.cyc));
          check("grant_id", 32'(grant_id), 32'(live.id));
          check("issue_we", 32'(mem_we), 32'(live.we));
          check("issue_addr", mem_addr, live.addr);
          check("issue_width", 32'(mem_width), 32'(live.width));
          check("issue_data", mem_wdata, live.data);
        end
      end else if (mem_ce) begin
        check("hold_fields", 32'({mem_we, mem_width}), 32'({live.we, live.width}));
        check("hold_addr", mem_addr, live.addr);
        check("hold_data", mem_wdata, live.data);
      end

      if (req_ready != '0) begin
        if (cpl_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ready_unexpected: got req_ready_o=%b required none (cycle %0d)",
                   req_ready, cyc);
        end else begin
          got = cpl_q.pop_front();
          check("ready_cycle", 32'(cyc), 32'(got.cyc));
          check("ready_onehot", 32'(req_ready), 32'(1) << got.id);
          check("ready_data", req_rdata[got.id], got.data);
          for (int i = 0; i < N; i++) check("rdata_hold", req_rdata[i], exp_rdata[i]);
          $display("txn cycle=%0d req%0d %s addr=%h width=%h data=%h", cyc, got.id,
                   got.we ? "WR" : "RD", got.addr, got.width, got.data);
        end
      end

      check("busy", 32'(busy), 32'(mem_ce | (req_ready != '0)));
      check("grant_hold", 32'(grant_id), 32'(m_gid));
      prev_ce = mem_ce;
    end
  end

  task automatic run(input int n, input int pn, input int pd, input int ps);
    p_new   = pn;
    p_drop  = pd;
    p_stray = ps;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_step(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_ce    = '0;
    req_we    = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = '0;
      req_width[i] = '0;
      req_wdata[i] = '0;
      active[i]    = 1'b0;
      granted[i]   = 1'b0;
      done[i]      = 1'b0;
      exp_rdata[i] = '0;
    end
    p_new = 0; p_drop = 0; p_stray = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_step(1'b1, 1'b0);
    end

    // All requesters held high: strict rotation 0,1,2,3,0...
    run(60, 100, 0, 0);
    // Mixed random traffic with ce drops and stray downstream readies.
    run(800, 30, 15, 10);

    // Reset in the middle of an outstanding access, then a late downstream ready.
    p_new = 100; p_drop = 0; p_stray = 0;
    for (int c = 0; c < 20 && m_state != 1; c++) begin
      @(negedge clk);
      drive_step(1'b0, 1'b0);
    end
    @(negedge clk);
    drive_step(1'b1, 1'b0);
    p_new = 0;
    @(negedge clk);
    drive_step(1'b0, 1'b1);

    // Rotation must restart from requester 0 after reset.
    run(30, 100, 0, 0);
    run(300, 40, 40, 30);
    // Drain so every outstanding access completes.
    run(40, 0, 0, 0);

    @(negedge clk);
    check("req_q_empty", 32'(req_q.size()), 32'h0);
    check("cpl_q_empty", 32'(cpl_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
